// File: rtl/dbg_scan_pkg.sv
// rtl/dbg_scan_pkg.sv - shared mode encodings, sentinel and select decoder for dbg_scan
package dbg_scan_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_AUTO = 2'b01,
        MODE_STEP = 2'b10
    } mode_e;

    localparam logic [31:0] DEFAULT_SENTINEL = 32'hFFFF_FFFF;
    localparam int          SEL_MAX          = 32;

    typedef struct packed {
        logic       valid;
        logic [4:0] idx;
    } sel_dec_t;

    // Index of the single set bit; anything other than exactly one bit set decodes to 0, invalid.
    function automatic sel_dec_t onehot_decode(input logic [SEL_MAX-1:0] vec);
        sel_dec_t    res;
        int unsigned cnt;
        res.valid = 1'b0;
        res.idx   = '0;
        cnt       = 0;
        for (int i = 0; i < SEL_MAX; i++) begin
            if (vec[i]) begin
                cnt     = cnt + 1;
                res.idx = 5'(i);
            end
        end
        res.valid = (cnt == 1);
        if (!res.valid) begin
            res.idx = '0;
        end
        return res;
    endfunction

endpackage

// File: rtl/dbg_tick_gen.sv
// rtl/dbg_tick_gen.sv - free-running divider with auto tick and step edge pulse
module dbg_tick_gen #(
    parameter int DIV_W    = 28,
    parameter int FAST_BIT = 25,
    parameter int SLOW_BIT = 27
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_slow,
    input  logic i_step,
    output logic o_tick,
    output logic o_step_pulse
);

    logic [DIV_W-1:0] r_div;
    logic             r_bit_prev;
    logic             r_slow_prev;
    logic             r_step_prev;
    logic             w_bit;

    assign w_bit = i_slow ? r_div[SLOW_BIT] : r_div[FAST_BIT];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div       <= '0;
            r_bit_prev  <= 1'b0;
            r_slow_prev <= 1'b0;
            r_step_prev <= 1'b0;
        end else begin
            r_div       <= r_div + 1'b1;
            r_bit_prev  <= w_bit;
            r_slow_prev <= i_slow;
            r_step_prev <= i_step;
        end
    end

    // On a slow/fast swap r_bit_prev belongs to the other bit, so that cycle is masked.
    assign o_tick       = w_bit & ~r_bit_prev & (i_slow == r_slow_prev);
    assign o_step_pulse = i_step & ~r_step_prev;

endmodule

// File: rtl/dbg_scan.sv
// rtl/dbg_scan.sv - multi-channel debug scan engine feeding the 7-segment display
module dbg_scan
    import dbg_scan_pkg::*;
#(
    parameter int             NCH      = 4,
    parameter int             AW       = 6,
    parameter int             DW       = 32,
    parameter int             DIV_W    = 28,
    parameter int             FAST_BIT = 25,
    parameter int             SLOW_BIT = 27,
    parameter logic [DW-1:0]  SENTINEL = DW'(DEFAULT_SENTINEL),
    localparam int            CW       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [1:0]        i_mode,
    input  logic              i_slow,
    input  logic              i_step,
    input  logic [NCH-1:0]    i_ch_sel,
    input  logic [NCH*AW-1:0] i_ch_last,
    output logic [NCH*AW-1:0] o_rd_addr,
    input  logic [NCH*DW-1:0] i_rd_data,
    output logic [DW-1:0]     o_disp_data,
    output logic [CW-1:0]     o_disp_ch,
    output logic [AW-1:0]     o_disp_addr,
    output logic              o_disp_sent,
    output logic              o_ch_err
);

    logic           w_tick;
    logic           w_step_pulse;
    sel_dec_t       w_sel;
    logic [CW-1:0]  w_cur;
    logic [CW-1:0]  r_cur_prev;
    logic           w_adv;
    logic [NCH-1:0] w_sent;

    dbg_tick_gen #(
        .DIV_W    (DIV_W),
        .FAST_BIT (FAST_BIT),
        .SLOW_BIT (SLOW_BIT)
    ) u_tick_gen (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_slow       (i_slow),
        .i_step       (i_step),
        .o_tick       (w_tick),
        .o_step_pulse (w_step_pulse)
    );

    assign w_sel = onehot_decode(SEL_MAX'(i_ch_sel));
    assign w_cur = w_sel.idx[CW-1:0];

    // A channel switch swallows any coincident advance so the new channel starts where it was left.
    assign w_adv = w_sel.valid && (w_cur == r_cur_prev) &&
                   (((i_mode == MODE_AUTO) && w_tick) ||
                    ((i_mode == MODE_STEP) && w_step_pulse));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cur_prev <= '0;
        end else begin
            r_cur_prev <= w_cur;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [AW-1:0] r_addr;
        logic          r_sent;
        logic [AW-1:0] w_last;

        assign w_last = i_ch_last[k*AW +: AW];

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_addr <= '0;
                r_sent <= 1'b0;
            end else if (w_adv && (w_cur == CW'(k))) begin
                if (r_sent) begin
                    r_addr <= '0;
                    r_sent <= 1'b0;
                end else if (r_addr >= w_last) begin
                    // >= also catches a limit lowered beneath the current address.
                    r_sent <= 1'b1;
                end else begin
                    r_addr <= r_addr + 1'b1;
                end
            end
        end

        assign o_rd_addr[k*AW +: AW] = r_addr;
        assign w_sent[k]             = r_sent;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_disp_data <= '0;
            o_disp_ch   <= '0;
            o_disp_addr <= '0;
            o_disp_sent <= 1'b0;
            o_ch_err    <= 1'b0;
        end else begin
            o_disp_data <= w_sent[w_cur] ? SENTINEL : i_rd_data[w_cur*DW +: DW];
            o_disp_ch   <= w_cur;
            o_disp_addr <= o_rd_addr[w_cur*AW +: AW];
            o_disp_sent <= w_sent[w_cur];
            o_ch_err    <= ~w_sel.valid;
        end
    end

endmodule

// File: tb/tb_dbg_scan.sv
// tb/tb_dbg_scan.sv - directed self-checking bench for dbg_scan
module tb_dbg_scan;

    localparam int NCH      = 4;
    localparam int AW       = 6;
    localparam int DW       = 32;
    localparam int DIV_W    = 8;
    localparam int FAST_BIT = 2;
    localparam int SLOW_BIT = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        mode;
    logic              slow;
    logic              step;
    logic [NCH-1:0]    ch_sel;
    logic [NCH*AW-1:0] ch_last;
    logic [NCH*AW-1:0] rd_addr;
    logic [NCH*DW-1:0] rd_data;
    logic [DW-1:0]     disp_data;
    logic [1:0]        disp_ch;
    logic [AW-1:0]     disp_addr;
    logic              disp_sent;
    logic              ch_err;

    int checks = 0;
    int errors = 0;
    int n;

    logic [AW-1:0] auto_addr [5] = '{6'd1, 6'd2, 6'd3, 6'd3, 6'd0};
    logic          auto_sent [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [DW-1:0] auto_data [5] = '{32'hA501_0001, 32'hA501_0002, 32'hA501_0003,
                                     32'hFFFF_FFFF, 32'hA501_0000};

    always #5 clk = ~clk;

    dbg_scan #(
        .NCH      (NCH),
        .AW       (AW),
        .DW       (DW),
        .DIV_W    (DIV_W),
        .FAST_BIT (FAST_BIT),
        .SLOW_BIT (SLOW_BIT),
        .SENTINEL (32'hFFFF_FFFF)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_mode      (mode),
        .i_slow      (slow),
        .i_step      (step),
        .i_ch_sel    (ch_sel),
        .i_ch_last   (ch_last),
        .o_rd_addr   (rd_addr),
        .i_rd_data   (rd_data),
        .o_disp_data (disp_data),
        .o_disp_ch   (disp_ch),
        .o_disp_addr (disp_addr),
        .o_disp_sent (disp_sent),
        .o_ch_err    (ch_err)
    );

    // Memory model: word = A5, channel, address.
    function automatic logic [DW-1:0] mem_word(input int k, input logic [AW-1:0] a);
        return {8'hA5, 8'(k), 10'h000, a};
    endfunction

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NCH; k++) begin
            rd_data[k*DW +: DW] = mem_word(k, rd_addr[k*AW +: AW]);
        end
    end

    task automatic cyc(input int cnt);
        repeat (cnt) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_step;
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        cyc(1);
    endtask

    task automatic wait_change(output int cycles);
        logic [AW:0] snap;
        snap   = {disp_addr, disp_sent};
        cycles = 0;
        while (({disp_addr, disp_sent} === snap) && (cycles < 40)) begin
            cyc(1);
            cycles++;
        end
    endtask

    initial begin
        rst     = 1'b1;
        mode    = 2'($urandom);
        slow    = 1'($urandom);
        step    = 1'($urandom);
        ch_sel  = 4'($urandom);
        ch_last = 24'($urandom);
        cyc(1);
        chk("rst_disp_data", disp_data, 32'h0);
        chk("rst_disp_ch", disp_ch, 2'd0);
        chk("rst_disp_addr", disp_addr, 6'd0);
        chk("rst_disp_sent", disp_sent, 1'b0);
        chk("rst_ch_err", ch_err, 1'b0);
        chk("rst_rd_addr", rd_addr, 24'h0);
        cyc(2);

        rst     = 1'b0;
        mode    = 2'b00;
        slow    = 1'b0;
        step    = 1'b0;
        ch_sel  = 4'b0001;
        ch_last = {6'd3, 6'd3, 6'd3, 6'd3};
        cyc(1);
        chk("rel_disp_data", disp_data, 32'hA500_0000);
        chk("rel_disp_addr", disp_addr, 6'd0);

        ch_sel = 4'b0010;
        cyc(2);
        chk("ch1_disp_ch", disp_ch, 2'd1);
        chk("ch1_disp_data", disp_data, 32'hA501_0000);

        mode = 2'b01;
        for (int i = 0; i < 5; i++) begin
            wait_change(n);
            if (i == 0) chk("auto_first_lat", 64'(n >= 1 && n <= 9), 64'd1);
            else        chk("auto_period", 64'(n), 64'd8);
            chk("auto_addr", disp_addr, auto_addr[i]);
            chk("auto_sent", disp_sent, auto_sent[i]);
            chk("auto_data", disp_data, auto_data[i]);
        end

        mode = 2'b10;
        ch_last[1*AW +: AW] = 6'd10;
        step = 1'b1;
        cyc(10);
        chk("step_hold_addr", disp_addr, 6'd1);
        step = 1'b0;
        cyc(2);
        step = 1'b1;
        cyc(3);
        step = 1'b0;
        cyc(2);
        chk("step_rearm_addr", disp_addr, 6'd2);
        chk("step_rd_addr1", rd_addr[1*AW +: AW], 6'd2);

        ch_last[2*AW +: AW] = 6'd10;
        ch_sel = 4'b0100;
        cyc(2);
        chk("sw_ch2_start", disp_addr, 6'd0);
        repeat (5) do_step;
        cyc(1);
        chk("sw_ch2_addr", disp_addr, 6'd5);
        ch_sel = 4'b0010;
        step   = 1'b1;
        cyc(1);
        step = 1'b0;
        cyc(2);
        chk("sw_back_ch", disp_ch, 2'd1);
        chk("sw_back_addr", disp_addr, 6'd2);
        chk("sw_back_data", disp_data, 32'hA501_0002);

        mode   = 2'b01;
        ch_sel = 4'b0110;
        cyc(20);
        chk("inv_ch_err", ch_err, 1'b1);
        chk("inv_disp_ch", disp_ch, 2'd0);
        chk("inv_disp_data", disp_data, 32'hA500_0000);
        chk("inv_rd_addr", rd_addr, {6'd0, 6'd5, 6'd2, 6'd0});

        mode   = 2'b00;
        ch_sel = 4'b1000;
        ch_last[3*AW +: AW] = 6'd1;
        cyc(2);
        chk("ch3_err_clear", ch_err, 1'b0);
        chk("ch3_disp_ch", disp_ch, 2'd3);
        mode = 2'b10;
        do_step;
        do_step;
        cyc(1);
        chk("ch3_sent", disp_sent, 1'b1);
        chk("ch3_sent_data", disp_data, 32'hFFFF_FFFF);
        chk("ch3_sent_addr", disp_addr, 6'd1);

        rst = 1'b1;
        cyc(1);
        chk("mid_rst_rd_addr", rd_addr, 24'h0);
        chk("mid_rst_sent", disp_sent, 1'b0);
        chk("mid_rst_data", disp_data, 32'h0);
        rst = 1'b0;
        cyc(2);
        chk("post_rst_ch", disp_ch, 2'd3);
        chk("post_rst_addr", disp_addr, 6'd0);
        chk("post_rst_sent", disp_sent, 1'b0);
        chk("post_rst_data", disp_data, 32'hA503_0000);
        do_step;
        cyc(1);
        chk("post_rst_step", disp_addr, 6'd1);

        ch_last[3*AW +: AW] = 6'd3;
        do_step;
        do_step;
        cyc(1);
        chk("low_pre_addr", disp_addr, 6'd3);
        ch_last[3*AW +: AW] = 6'd1;
        do_step;
        cyc(1);
        chk("low_sent", disp_sent, 1'b1);
        chk("low_sent_addr", disp_addr, 6'd3);
        do_step;
        cyc(1);
        chk("low_wrap_addr", disp_addr, 6'd0);
        chk("low_wrap_sent", disp_sent, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
